// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared encodings and types for the WISC hazard/forwarding control.
// Rev     : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // Write-back source select, shared with the decode stage.
    typedef enum logic [1:0] {
        WB_PC  = 2'b00,
        WB_MEM = 2'b01,
        WB_ALU = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_t;

    // Forwarding word: {enable, from_mem, source}. All-zero means register file.
    typedef struct packed {
        logic       en;
        logic       from_mem;
        logic [1:0] src;
    } fw_word_t;

    localparam fw_word_t FW_NONE = '{en: 1'b0, from_mem: 1'b0, src: 2'b00};

    // Slots store the widest supported register index so the type is fixed.
    localparam int SB_REG_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic [SB_REG_MAX-1:0] rnum;
        logic [1:0]            wb_sel;
    } sb_slot_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module  : fwd_sel
// Brief   : Per-operand forwarding/interlock decision against the X and M slots.
//           HAZ_FWD_EN selects forwarding; otherwise every match interlocks.
// Rev     : 1.0  initial release
// ============================================================================
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_W = 3
) (
    input  sb_slot_t         x_slot,
    input  sb_slot_t         m_slot,
    input  logic [REG_W-1:0] src,
    input  logic             rd_en,
    output logic [3:0]       fw_word,
    output logic             hit
);

    logic     x_match;
    logic     m_match;
    fw_word_t word;

    assign x_match = rd_en && x_slot.valid && (x_slot.rnum == SB_REG_MAX'(src));
    assign m_match = rd_en && m_slot.valid && (m_slot.rnum == SB_REG_MAX'(src));

`ifdef HAZ_FWD_EN
    // The younger producer (X) holds the newest value, so it wins.
    always_comb begin
        word = FW_NONE;
        if (x_match) begin
            word = '{en: 1'b1, from_mem: 1'b0, src: x_slot.wb_sel};
        end else if (m_match) begin
            word = '{en: 1'b1, from_mem: 1'b1, src: m_slot.wb_sel};
        end
    end

    assign hit = x_match && (x_slot.wb_sel == WB_MEM);
`else
    logic unused_wb;

    assign word      = FW_NONE;
    assign hit       = x_match || m_match;
    assign unused_wb = ^{x_slot.wb_sel, m_slot.wb_sel};
`endif

    assign fw_word = word;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Hazard/forwarding controller for the 5-stage WISC pipeline.
//           Macro HAZ_FWD_EN enables operand forwarding (else full interlock).
// Rev     : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_rs_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rt_rd,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic [1:0]       id_wb_sel,
    input  logic             id_halt,
    input  logic             ex_redirect,
    output logic [3:0]       fw_cntrl_a,
    output logic [3:0]       fw_cntrl_b,
    output logic             stall_fd,
    output logic             flush_fd,
    output logic             bubble_x,
    output logic             halt_ok
);

    sb_slot_t   x_q, x_d, m_q, m_d;
    state_t     state_q, state_d;
    logic [3:0] fw_a_q, fw_a_d, fw_b_q, fw_b_d;
    logic [3:0] word_a, word_b;
    logic       hit_a, hit_b, hazard, advance;

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .x_slot  (x_q),
        .m_slot  (m_q),
        .src     (id_rs),
        .rd_en   (id_valid && id_rs_rd),
        .fw_word (word_a),
        .hit     (hit_a)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .x_slot  (x_q),
        .m_slot  (m_q),
        .src     (id_rt),
        .rd_en   (id_valid && id_rt_rd),
        .fw_word (word_b),
        .hit     (hit_b)
    );

    assign hazard = hit_a || hit_b;

    // STALL behaves like RUN: the bubble it inserted is the one-cycle wait.
    always_comb begin
        state_d  = state_q;
        stall_fd = 1'b0;
        flush_fd = 1'b0;
        bubble_x = 1'b0;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (ex_redirect) begin
                    flush_fd = 1'b1;
                    bubble_x = 1'b1;
                    state_d  = ST_RUN;
                end else if (hazard) begin
                    stall_fd = 1'b1;
                    bubble_x = 1'b1;
                    state_d  = ST_STALL;
                end else if (id_valid && id_halt) begin
                    state_d  = ST_DRAIN;
                end else begin
                    state_d  = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (ex_redirect) begin
                    flush_fd = 1'b1;
                    bubble_x = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    stall_fd = 1'b1;
                    bubble_x = 1'b1;
                    if (!x_q.valid && !m_q.valid) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                stall_fd = 1'b1;
                bubble_x = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        advance = !stall_fd && !bubble_x;
        m_d     = x_q;
        x_d     = '0;
        fw_a_d  = 4'b0000;
        fw_b_d  = 4'b0000;
        if (advance) begin
            fw_a_d = word_a;
            fw_b_d = word_b;
            if (id_valid && id_wr_en) begin
                x_d = '{valid: 1'b1, rnum: SB_REG_MAX'(id_wr_reg), wb_sel: id_wb_sel};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            x_q     <= '0;
            m_q     <= '0;
            fw_a_q  <= 4'b0000;
            fw_b_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            m_q     <= m_d;
            fw_a_q  <= fw_a_d;
            fw_b_q  <= fw_b_d;
        end
    end

    assign fw_cntrl_a = fw_a_q;
    assign fw_cntrl_b = fw_b_q;
    assign halt_ok    = (state_q == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Self-checking bench for hazard_ctrl (directed table, corner
//           sequences, random stimulus against a pipeline-occupancy model).
// Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [1:0] B_PC = 2'b00, B_MEM = 2'b01, B_ALU = 2'b10, B_IMM = 2'b11;

    typedef struct {
        logic       v;
        logic       rs_rd;
        logic [2:0] rs;
        logic       rt_rd;
        logic [2:0] rt;
        logic       we;
        logic [2:0] wr;
        logic [1:0] wb;
        logic       halt;
        logic       redir;
    } in_t;

    typedef struct {
        in_t         i;
        logic [11:0] e;   // {stall, flush, bubble, halt_ok, fw_a, fw_b}
    } vec_t;

    typedef struct {
        bit         w;
        logic [2:0] rg;
        logic [1:0] wb;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs_rd, id_rt_rd, id_wr_en, id_halt, ex_redirect;
    logic [2:0] id_rs, id_rt, id_wr_reg;
    logic [1:0] id_wb_sel;
    wire  [3:0] fw_cntrl_a, fw_cntrl_b;
    wire        stall_fd, flush_fd, bubble_x, halt_ok;

    hazard_ctrl #(.REG_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs_rd    (id_rs_rd),
        .id_rs       (id_rs),
        .id_rt_rd    (id_rt_rd),
        .id_rt       (id_rt),
        .id_wr_en    (id_wr_en),
        .id_wr_reg   (id_wr_reg),
        .id_wb_sel   (id_wb_sel),
        .id_halt     (id_halt),
        .ex_redirect (ex_redirect),
        .fw_cntrl_a  (fw_cntrl_a),
        .fw_cntrl_b  (fw_cntrl_b),
        .stall_fd    (stall_fd),
        .flush_fd    (flush_fd),
        .bubble_x    (bubble_x),
        .halt_ok     (halt_ok)
    );

    always #5 clk = ~clk;

    wire [11:0] obs = {stall_fd, flush_fd, bubble_x, halt_ok, fw_cntrl_a, fw_cntrl_b};

    int   checks = 0;
    int   errors = 0;
    ent_t pipe[$];          // instructions that entered EX, newest last
    int   mode;             // 0 running, 1 draining, 2 halted
    logic [3:0] m_fa, m_fb;

    function automatic in_t mk(input logic v, rsr, input int rs, input logic rtr, input int rt,
                               input logic we, input int wr, input logic [1:0] wb,
                               input logic hl, rd);
        in_t x;
        x.v = v; x.rs_rd = rsr; x.rs = 3'(rs); x.rt_rd = rtr; x.rt = 3'(rt);
        x.we = we; x.wr = 3'(wr); x.wb = wb; x.halt = hl; x.redir = rd;
        return x;
    endfunction

    function automatic logic [11:0] ex(input logic s, f, b, h, input logic [3:0] fa, fb);
        return {s, f, b, h, fa, fb};
    endfunction

    task automatic apply(input in_t x);
        id_valid = x.v; id_rs_rd = x.rs_rd; id_rs = x.rs; id_rt_rd = x.rt_rd; id_rt = x.rt;
        id_wr_en = x.we; id_wr_reg = x.wr; id_wb_sel = x.wb; id_halt = x.halt;
        ex_redirect = x.redir;
    endtask

    task automatic check(input string name, input logic [11:0] e);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s: got s/f/b/h=%b fa=%b fb=%b, want s/f/b/h=%b fa=%b fb=%b",
                     name, obs[11:8], obs[7:4], obs[3:0], e[11:8], e[7:4], e[3:0]);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input in_t x, input logic [11:0] e, input string name);
        apply(x);
        #1;
        check(name, e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, B_PC, 0, 0));
        pipe.delete();
        mode = 0; m_fa = 4'b0; m_fb = 4'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset", 12'b0);
        @(negedge clk);
    endtask

    // Distance (1 = one ahead, 2 = two ahead) to the nearest in-flight writer of src.
    function automatic int nearest(input logic rd, input logic [2:0] src);
        if (!rd) return 0;
        for (int d = 1; d <= 2; d++)
            if (pipe.size() >= d && pipe[pipe.size()-d].w && pipe[pipe.size()-d].rg == src)
                return d;
        return 0;
    endfunction

    function automatic logic [3:0] fword(input int d);
        if (!FWD || d == 0) return 4'b0000;
        return {1'b1, (d == 2), pipe[pipe.size()-d].wb};
    endfunction

    function automatic bit must_wait(input int d);
        if (FWD) return (d == 1) && (pipe[pipe.size()-1].wb == B_MEM);
        return d != 0;
    endfunction

    task automatic model_cycle(input in_t x, output logic [11:0] e);
        int         da, db;
        logic       hz, s, f, b, quiet;
        logic [3:0] wa, wb;
        da = nearest(x.v && x.rs_rd, x.rs);
        db = nearest(x.v && x.rt_rd, x.rt);
        wa = fword(da);
        wb = fword(db);
        hz = must_wait(da) || must_wait(db);
        s = 1'b0; f = 1'b0; b = 1'b0;
        if (mode == 2)            begin s = 1'b1; b = 1'b1; end
        else if (x.redir)         begin f = 1'b1; b = 1'b1; end
        else if (mode == 1 || hz) begin s = 1'b1; b = 1'b1; end
        e = {s, f, b, (mode == 2), m_fa, m_fb};
        quiet = !(pipe.size() >= 1 && pipe[pipe.size()-1].w) &&
                !(pipe.size() >= 2 && pipe[pipe.size()-2].w);
        if (mode == 0 && !x.redir && !hz && x.v && x.halt) mode = 1;
        else if (mode == 1 && x.redir)                     mode = 0;
        else if (mode == 1 && quiet)                       mode = 2;
        if (!s && !b) begin
            m_fa = wa; m_fb = wb;
            pipe.push_back('{x.v && x.we, x.wr, x.wb});
        end else begin
            m_fa = 4'b0; m_fb = 4'b0;
            pipe.push_back('{1'b0, 3'b0, 2'b0});
        end
        if (pipe.size() > 2) void'(pipe.pop_front());
    endtask

    function automatic in_t rand_in();
        in_t x;
        x.v     = ($urandom_range(0, 7) != 0);
        x.rs_rd = 1'($urandom_range(0, 1));
        x.rs    = 3'($urandom_range(0, 3));
        x.rt_rd = 1'($urandom_range(0, 1));
        x.rt    = 3'($urandom_range(0, 3));
        x.we    = 1'($urandom_range(0, 1));
        x.wr    = 3'($urandom_range(0, 3));
        x.wb    = 2'($urandom_range(0, 3));
        x.halt  = ($urandom_range(0, 39) == 0);
        x.redir = ($urandom_range(0, 9) == 0);
        return x;
    endfunction

    initial begin
        vec_t        tbl[14];
        in_t         nop, sub, cons;
        logic [11:0] e, stl, nul;

        nop = mk(0, 0, 0, 0, 0, 0, 0, B_PC, 0, 0);
        sub = mk(1, 1, 2, 1, 1, 1, 4, B_ALU, 0, 0);
        stl = ex(1, 0, 1, 0, 4'b0, 4'b0);
        nul = 12'b0;

        tbl[0]  = '{mk(1, 1, 2, 1, 3, 1, 1, B_ALU, 0, 0), nul};
        tbl[1]  = '{mk(1, 1, 1, 1, 3, 1, 2, B_ALU, 0, 0), FWD ? nul : stl};
        tbl[2]  = '{nop, FWD ? ex(0, 0, 0, 0, 4'b1010, 4'b0) : nul};
        tbl[3]  = '{nop, nul};
        tbl[4]  = '{mk(1, 1, 5, 0, 0, 1, 1, B_MEM, 0, 0), nul};
        tbl[5]  = '{sub, stl};
        tbl[6]  = '{sub, FWD ? nul : stl};
        tbl[7]  = '{mk(1, 0, 0, 0, 0, 1, 5, B_IMM, 0, 0), FWD ? ex(0, 0, 0, 0, 4'b0, 4'b1101) : nul};
        tbl[8]  = '{nop, nul};
        tbl[9]  = '{mk(1, 1, 5, 1, 5, 1, 6, B_ALU, 0, 0), FWD ? nul : stl};
        tbl[10] = '{mk(1, 1, 7, 0, 0, 1, 3, B_MEM, 0, 0), FWD ? ex(0, 0, 0, 0, 4'b1111, 4'b1111) : nul};
        tbl[11] = '{mk(1, 1, 3, 0, 0, 1, 0, B_ALU, 0, 1), ex(0, 1, 1, 0, 4'b0, 4'b0)};
        tbl[12] = '{mk(1, 1, 3, 0, 0, 1, 0, B_ALU, 0, 0), FWD ? nul : stl};
        tbl[13] = '{nop, FWD ? ex(0, 0, 0, 0, 4'b1101, 4'b0) : nul};

        do_reset();
        for (int k = 0; k < 14; k++) step(tbl[k].i, tbl[k].e, $sformatf("vec%0d", k));

        // HALT behind two ALU writers: two DRAIN cycles, then halt_ok held.
        do_reset();
        step(mk(1, 0, 0, 0, 0, 1, 1, B_ALU, 0, 0), nul, "halt_w1");
        step(mk(1, 1, 4, 1, 5, 1, 2, B_ALU, 0, 0), nul, "halt_w2");
        step(mk(1, 0, 0, 0, 0, 0, 0, B_PC, 1, 0), nul, "halt_issue");
        step(nop, stl, "drain1");
        step(nop, stl, "drain2");
        step(nop, ex(1, 0, 1, 1, 4'b0, 4'b0), "halted1");
        step(nop, ex(1, 0, 1, 1, 4'b0, 4'b0), "halted2");
        rst = 1'b1;
        #1;
        check("abort_halt", nul);
        @(negedge clk);

        // Redirect during DRAIN returns to normal running.
        do_reset();
        step(mk(1, 0, 0, 0, 0, 1, 1, B_ALU, 0, 0), nul, "rd_w1");
        step(mk(1, 0, 0, 0, 0, 0, 0, B_PC, 1, 0), nul, "rd_halt");
        step(mk(0, 0, 0, 0, 0, 0, 0, B_PC, 0, 1), ex(0, 1, 1, 0, 4'b0, 4'b0), "rd_drain");
        step(nop, nul, "rd_run1");
        step(nop, nul, "rd_run2");

        // Asynchronous reset while a stall is being asserted.
        do_reset();
        cons = mk(1, 1, 1, 0, 0, 1, 2, B_ALU, 0, 0);
        step(mk(1, 0, 0, 0, 0, 1, 1, B_MEM, 0, 0), nul, "ab_load");
        apply(cons);
        #1;
        check("ab_stall", stl);
        rst = 1'b1;
        #1;
        check("abort_stall", nul);
        @(negedge clk);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0 || (mode == 2 && $urandom_range(0, 3) == 0))
                do_reset();
            begin
                in_t x;
                x = rand_in();
                apply(x);
                model_cycle(x, e);
                #1;
                check($sformatf("rand%0d", n), e);
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the five-stage WISC pipeline. It keeps a shadow scoreboard of in-flight register writers in the EX and MEM stages. From that scoreboard it produces the registered 4-bit forwarding control words used by the execute-stage operand muxes, and it sequences load-use stalls, taken-branch squashes and halt drain. It sits beside the decode stage and drives the IF/ID and ID/EX pipeline-register enables and clears.

## Interface
Parameters:
- REG_W, 3: register-index width (8 architectural registers, all writable, no hardwired zero)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  a real instruction occupies decode
- id_rs_rd  in  1  decode instruction reads rs
- id_rs  in  REG_W  rs index
- id_rt_rd  in  1  decode instruction reads rt
- id_rt  in  REG_W  rt index
- id_wr_en  in  1  decode instruction writes a register
- id_wr_reg  in  REG_W  destination index
- id_wb_sel  in  2  write-back source: 00 addPC, 01 memory, 10 ALU, 11 imm8
- id_halt  in  1  decode instruction is HALT
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle
- fw_cntrl_a  out  4  forwarding word for operand A, aligned to EX
- fw_cntrl_b  out  4  forwarding word for operand B, aligned to EX
- stall_fd  out  1  hold PC and IF/ID
- flush_fd  out  1  clear IF/ID to NOP
- bubble_x  out  1  load NOP into ID/EX
- halt_ok  out  1  pipeline drained behind HALT; held until reset

## Operation
Forwarding-word format:
- [3] = forward enable
- [2] = 0 selects EX->EX (one instruction ahead), 1 selects MEM->EX (two ahead)
- [1:0] = source, using the id_wb_sel encoding
- A word of 4'b0000 means the operand comes from the register file.

Scoreboard:
- Slots X and M each hold {valid, reg, wb_sel}.
- On advance (no stall): ID info moves to X and X moves to M. ID info enters X only if id_valid and id_wr_en; otherwise X is cleared.
- On stall or bubble: X is cleared and X moves to M.

Forwarding decision, computed in decode and registered into fw_cntrl_* on advance:
- If the X slot matches the source register: word = {1,0,X.wb_sel}.
- Else if the M slot matches: word = {1,1,M.wb_sel}.
- Else: word = 0.
- The X slot has priority over M.

Load-use stall:
- Condition: X slot valid with wb_sel = 01 and it matches a read source in decode.
- Response: stall_fd = 1 and bubble_x = 1 for exactly one cycle.
- Next cycle the load is in M, so the word becomes {1,1,01}.

FSM states: RUN, STALL, DRAIN, HALTED.
- RUN -> STALL on a load-use hazard.
- STALL -> RUN after one cycle, then re-evaluate.
- RUN -> DRAIN when id_valid & id_halt. In DRAIN, stall_fd = 1 and bubble_x = 1.
- DRAIN -> HALTED when X and M are both invalid. HALTED asserts halt_ok, stall_fd and bubble_x.

Redirect:
- ex_redirect forces flush_fd = 1 and bubble_x = 1 that cycle, with stall_fd = 0.
- Redirect overrides a load-use stall.
- A redirect in DRAIN returns the FSM to RUN, because the HALT was on the wrong path.

## Timing
- stall_fd, flush_fd and bubble_x are combinational from the inputs and the scoreboard in the same cycle.
- fw_cntrl_a and fw_cntrl_b are registered: valid the cycle the consumer is in EX. They are cleared to 0 on bubble.
- Reset values: FSM = RUN, scoreboard invalid, fw_cntrl_* = 0, halt_ok = 0. stall_fd, flush_fd and bubble_x are 0 once rst is released.
- Asserting rst mid-stall or mid-drain aborts immediately to the reset state.
- Back-to-back hazards: a second load-use against the same load cannot occur. A new load in decode during STALL is evaluated on return to RUN.

## Configuration
- Macro HAZ_FWD_EN.
- Defined: behaviour as above.
- Undefined: fw_cntrl_* are tied to 0. Any decode read that matches a valid X or M slot stalls, so the instruction waits 1–2 cycles until the producer leaves M. The register file writes before it reads, so WB needs no interlock.

## Structure
- Package hazard_pkg: wb_sel encodings, the fw-word field constants, the FSM state enum and the scoreboard-slot struct.
- Sub-module fwd_sel: one instance per operand. It takes {X, M, src, rd_en} and returns {fwd word, load-use hit}.

## Test plan
1. ADD r1 then ADD r2,r1,r3 -> fw_cntrl_a = 4'b1010 in the consumer's EX cycle, no stall.
2. LD r1 then SUB r4,r2,r1 -> one cycle of stall_fd/bubble_x, then fw_cntrl_b = 4'b1101.
3. LBI r5 (imm8), NOP, ADD r6,r5,r5 -> both words = 4'b1111.
4. Load-use hazard coincident with ex_redirect -> flush_fd = 1, bubble_x = 1, stall_fd = 0, FSM stays RUN.
5. HALT after two ALU writers -> DRAIN for 2 cycles, then halt_ok = 1 held. A redirect during DRAIN returns to RUN.
6. Without HAZ_FWD_EN: ADD r1 then ADD r2,r1,r1 -> 2 stall cycles, fw words 0. Assert rst mid-stall -> all outputs 0.
